// File: rtl/one_hot_cycle_controller.sv
// Sequencer for the one-hot FETCH/DECODE/EXECUTE instruction-cycle state register.
// Define FETCH_WATCHDOG_EN to add a watchdog that flags and retries unacknowledged fetches.
module one_hot_cycle_controller #(
    parameter int CNT_W    = 4,
    parameter int RET_W    = 16,
    parameter int WD_LIMIT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             stall,
    input  logic             scan_enable,
    output logic             fetch_req,
    input  logic             fetch_ack,
    input  logic [CNT_W-1:0] exec_cycles,
    output logic [2:0]       state,
    output logic [2:0]       state_next,
    output logic             state_load,
    output logic             exec_done,
    output logic [RET_W-1:0] retired,
    output logic             error
);

    typedef enum logic [2:0] {
        FETCH   = 3'b001,
        DECODE  = 3'b010,
        EXECUTE = 3'b100
    } state_t;

    if (WD_LIMIT < 1) begin : g_wd_limit_check
        $error("WD_LIMIT must be at least 1");
    end

    // Raw bits rather than state_t: corrupted non-one-hot values must stay representable.
    logic [2:0]       state_q;
    logic             req_q, req_d;
    logic             done_q, done_d;
    logic [RET_W-1:0] ret_q, ret_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

`ifdef FETCH_WATCHDOG_EN
    localparam int WD_W = $clog2(WD_LIMIT + 1);
    logic [WD_W-1:0] wd_q, wd_d;
`endif

    always_comb begin
        state_next = state_q;
        state_load = 1'b0;
        req_d      = req_q;
        done_d     = 1'b0;
        ret_d      = ret_q;
        err_d      = err_q;
        cnt_d      = cnt_q;
`ifdef FETCH_WATCHDOG_EN
        wd_d       = wd_q;
`endif
        if (rst) begin
            state_next = FETCH;
            state_load = 1'b1;
        end else if (scan_enable) begin
            done_d = done_q;
        end else begin
            case (state_q)
                FETCH: begin
                    // An outstanding request is never withdrawn by stall or run; only ack ends it.
                    if (req_q && fetch_ack) begin
                        req_d      = 1'b0;
                        state_next = DECODE;
                        state_load = 1'b1;
`ifdef FETCH_WATCHDOG_EN
                        wd_d       = '0;
`endif
                    end else if (req_q) begin
`ifdef FETCH_WATCHDOG_EN
                        if (wd_q == WD_W'(WD_LIMIT - 1)) begin
                            req_d = 1'b0;
                            err_d = 1'b1;
                            wd_d  = '0;
                        end else begin
                            wd_d = wd_q + WD_W'(1);
                        end
`endif
                    end else begin
                        req_d = run && !stall;
                    end
                end
                DECODE: begin
                    if (!stall) begin
                        cnt_d      = (exec_cycles == '0) ? '0 : exec_cycles - CNT_W'(1);
                        state_next = EXECUTE;
                        state_load = 1'b1;
                    end
                end
                EXECUTE: begin
                    if (!stall) begin
                        if (cnt_q == '0) begin
                            done_d     = 1'b1;
                            ret_d      = ret_q + RET_W'(1);
                            state_next = FETCH;
                            state_load = 1'b1;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_next = FETCH;
                    state_load = 1'b1;
                    req_d      = 1'b0;
                    cnt_d      = '0;
                    err_d      = 1'b1;
`ifdef FETCH_WATCHDOG_EN
                    wd_d       = '0;
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            ret_q   <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef FETCH_WATCHDOG_EN
            wd_q    <= '0;
`endif
        end else begin
            state_q <= state_next;
            req_q   <= req_d;
            done_q  <= done_d;
            ret_q   <= ret_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef FETCH_WATCHDOG_EN
            wd_q    <= wd_d;
`endif
        end
    end

    assign state     = state_q;
    assign fetch_req = req_q;
    assign exec_done = done_q;
    assign retired   = ret_q;
    assign error     = err_q;

endmodule

// File: tb/tb_one_hot_cycle_controller.sv
// Randomized and directed bench for one_hot_cycle_controller against a phase-level reference model.
module tb_one_hot_cycle_controller;

    localparam int CNT_W    = 4;
    localparam int RET_W    = 16;
    localparam int WD_LIMIT = 15;
    localparam int VEC_W    = RET_W + 10;

    logic             clk = 1'b0;
    logic             rst, run, stall, scan_enable, fetch_ack;
    logic [CNT_W-1:0] exec_cycles;
    logic             fetch_req, state_load, exec_done, error;
    logic [2:0]       state, state_next;
    logic [RET_W-1:0] retired;

    one_hot_cycle_controller #(.CNT_W(CNT_W), .RET_W(RET_W), .WD_LIMIT(WD_LIMIT)) dut (
        .clk(clk), .rst(rst), .run(run), .stall(stall), .scan_enable(scan_enable),
        .fetch_req(fetch_req), .fetch_ack(fetch_ack), .exec_cycles(exec_cycles),
        .state(state), .state_next(state_next), .state_load(state_load),
        .exec_done(exec_done), .retired(retired), .error(error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0/1/2 = fetch/decode/execute, m_left = execute cycles still owed.
    int               m_phase = 0;
    int               m_left = 0;
    int               m_wd = 0;
    logic             m_req = 1'b0, m_done = 1'b0, m_err = 1'b0;
    logic [RET_W-1:0] m_ret = '0;

    logic [2:0]       obs_next, exp_next, exp_state;
    logic             obs_load, exp_load;
    logic [VEC_W-1:0] obs_vec, exp_vec;

    task automatic tick();
        int old_phase;
        #3;
        obs_next = state_next;
        obs_load = state_load;
        @(posedge clk);
        old_phase = m_phase;
        if (rst) begin
            m_phase = 0; m_left = 0; m_wd = 0;
            m_req = 1'b0; m_done = 1'b0; m_err = 1'b0; m_ret = '0;
        end else if (!scan_enable) begin
            m_done = 1'b0;
            case (m_phase)
                0: begin
                    if (m_req && fetch_ack) begin
                        m_req = 1'b0; m_wd = 0; m_phase = 1;
                    end else if (m_req) begin
`ifdef FETCH_WATCHDOG_EN
                        m_wd++;
                        if (m_wd == WD_LIMIT) begin
                            m_req = 1'b0; m_err = 1'b1; m_wd = 0;
                        end
`endif
                    end else begin
                        m_req = run && !stall;
                    end
                end
                1: if (!stall) begin
                    m_left  = (exec_cycles == '0) ? 1 : int'(exec_cycles);
                    m_phase = 2;
                end
                default: if (!stall) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_done = 1'b1; m_ret++; m_phase = 0;
                    end
                end
            endcase
        end
        exp_state = 3'b001 << m_phase;
        exp_next  = exp_state;
        exp_load  = rst || (m_phase != old_phase);
        #1;
        obs_vec = {state, fetch_req, exec_done, retired, error, obs_next, obs_load};
        exp_vec = {exp_state, m_req, m_done, m_ret, m_err, exp_next, exp_load};
    endtask

    // Drives one instruction from an idle FETCH and records what happened.
    task automatic run_instr(input int ec, input int ack_delay, input int stall_at, input int stall_len,
                             input bit stall_fetch, input bit run_off,
                             output int exec_n, output int dones, output int loads, output int bad,
                             output int req_drops, output bit finished);
        int   req_hi = 0;
        bit   seen_exec = 1'b0;
        logic prev_req;
        exec_n = 0; dones = 0; loads = 0; bad = 0; req_drops = 0; finished = 1'b0;
        exec_cycles = CNT_W'(ec);
        for (int c = 0; c < 80 && !finished; c++) begin
            run       = !(run_off && seen_exec);
            stall     = (stall_fetch && state == 3'b001 && fetch_req) ||
                        (state == 3'b100 && exec_n >= stall_at && exec_n < stall_at + stall_len);
            fetch_ack = fetch_req && (req_hi >= ack_delay);
            prev_req  = fetch_req;
            tick();
            if (obs_vec !== exp_vec) bad++;
            if (obs_load) loads++;
            if (state == 3'b100) begin exec_n++; seen_exec = 1'b1; end
            if (exec_done) begin dones++; finished = 1'b1; end
            if (prev_req && !fetch_req && state == 3'b001) req_drops++;
            req_hi = fetch_req ? req_hi + 1 : 0;
        end
        run = 1'b0; stall = 1'b0; fetch_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; run = 1'b0; stall = 1'b0; scan_enable = 1'b0; fetch_ack = 1'b0; exec_cycles = '0;
        tick();
        tick();
        vectors++;
        if ({obs_next, obs_load} !== 4'b0011) begin
            miscompares++; $display("FAIL reset_next_load got=%b want=0011", {obs_next, obs_load});
        end
        vectors++;
        if ({state, fetch_req, exec_done, retired, error} !== {3'b001, 2'b00, 16'h0000, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values state=%b req=%b done=%b ret=%h err=%b want 001/0/0/0000/0",
                     state, fetch_req, exec_done, retired, error);
        end
        vectors++;
        if (obs_vec !== exp_vec) begin
            miscompares++; $display("FAIL reset_model got=%h want=%h", obs_vec, exp_vec);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int e, d, l, b, rd; bit fin; logic [RET_W-1:0] r0;
        r0 = retired;
        run_instr(3, 2, -1, 0, 1'b0, 1'b0, e, d, l, b, rd, fin);
        vectors++;
        if (!fin || b !== 0) begin
            miscompares++; $display("FAIL basic_trace finished=%0d bad_cycles=%0d want 1/0", fin, b);
        end
        vectors++;
        if (e !== 3) begin miscompares++; $display("FAIL basic_exec_len got=%0d want=3", e); end
        vectors++;
        if (l !== 3) begin miscompares++; $display("FAIL basic_loads got=%0d want=3", l); end
        vectors++;
        if (retired !== r0 + RET_W'(1)) begin
            miscompares++; $display("FAIL basic_retired got=%h want=%h", retired, r0 + RET_W'(1));
        end
        tick();
        vectors++;
        if (exec_done !== 1'b0 || state !== 3'b001 || d !== 1) begin
            miscompares++;
            $display("FAIL basic_done_pulse done=%b state=%b pulses=%0d want 0/001/1", exec_done, state, d);
        end
    endtask

    task automatic test_exec_zero();
        int e, d, l, b, rd; bit fin; logic [RET_W-1:0] r0;
        r0 = retired;
        run_instr(0, 0, -1, 0, 1'b0, 1'b0, e, d, l, b, rd, fin);
        vectors++;
        if (!fin || b !== 0 || e !== 1 || d !== 1) begin
            miscompares++;
            $display("FAIL exec_zero fin=%0d bad=%0d exec_len=%0d pulses=%0d want 1/0/1/1", fin, b, e, d);
        end
        vectors++;
        if (retired !== r0 + RET_W'(1)) begin
            miscompares++; $display("FAIL exec_zero_retired got=%h want=%h", retired, r0 + RET_W'(1));
        end
    endtask

    task automatic test_stall();
        int e, d, l, b, rd; bit fin;
        run_instr(5, 2, 2, 4, 1'b1, 1'b0, e, d, l, b, rd, fin);
        vectors++;
        if (!fin || b !== 0) begin
            miscompares++; $display("FAIL stall_trace finished=%0d bad_cycles=%0d want 1/0", fin, b);
        end
        vectors++;
        if (e !== 9) begin miscompares++; $display("FAIL stall_exec_len got=%0d want=9", e); end
        vectors++;
        if (rd !== 0) begin miscompares++; $display("FAIL stall_req_dropped got=%0d want=0", rd); end
    endtask

    task automatic test_run_low();
        int e, d, l, b, rd; bit fin; int bad_park = 0;
        run_instr(4, 1, -1, 0, 1'b0, 1'b1, e, d, l, b, rd, fin);
        vectors++;
        if (!fin || b !== 0 || e !== 4) begin
            miscompares++; $display("FAIL run_low_complete fin=%0d bad=%0d exec_len=%0d want 1/0/4", fin, b, e);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            if (obs_vec !== exp_vec || state !== 3'b001 || fetch_req !== 1'b0) bad_park++;
        end
        vectors++;
        if (bad_park !== 0) begin
            miscompares++; $display("FAIL run_low_park bad_cycles=%0d want=0 state=%b req=%b", bad_park, state, fetch_req);
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        run = 1'b1;
        while (!fetch_req && n < 5) begin tick(); n++; end
        vectors++;
        if (fetch_req !== 1'b1) begin miscompares++; $display("FAIL reset_mid_req_rise got=%b want=1", fetch_req); end
        rst = 1'b1;
        tick();
        vectors++;
        if (fetch_req !== 1'b0 || state !== 3'b001 || obs_vec !== exp_vec) begin
            miscompares++; $display("FAIL reset_mid_drop req=%b state=%b want 0/001", fetch_req, state);
        end
        rst = 1'b0; run = 1'b0;
        tick();
    endtask

    task automatic test_retire_wrap();
        int e, d, l, b, rd; bit fin;
        scan_enable = 1'b1;
        force dut.ret_q = 16'hFFFF;
        tick();
        release dut.ret_q;
        scan_enable = 1'b0;
        m_ret = 16'hFFFF;
        run_instr(2, 1, -1, 0, 1'b0, 1'b0, e, d, l, b, rd, fin);
        vectors++;
        if (!fin || b !== 0 || retired !== 16'h0000) begin
            miscompares++; $display("FAIL retire_wrap fin=%0d bad=%0d retired=%h want 1/0/0000", fin, b, retired);
        end
    endtask

    task automatic test_illegal();
        int err_lost = 0;
        run = 1'b0; scan_enable = 1'b1;
        tick();
        force dut.state_q = 3'b011;
        tick();
        release dut.state_q;
        vectors++;
        if (state !== 3'b011 || obs_load !== 1'b0) begin
            miscompares++; $display("FAIL illegal_scan_hold state=%b load=%b want 011/0", state, obs_load);
        end
        scan_enable = 1'b0;
        tick();
        vectors++;
        if ({obs_next, obs_load} !== 4'b0011) begin
            miscompares++; $display("FAIL illegal_recover_next got=%b want=0011", {obs_next, obs_load});
        end
        vectors++;
        if (state !== 3'b001 || error !== 1'b1 || fetch_req !== 1'b0) begin
            miscompares++; $display("FAIL illegal_recover state=%b err=%b req=%b want 001/1/0", state, error, fetch_req);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            if (error !== 1'b1) err_lost++;
        end
        vectors++;
        if (err_lost !== 0) begin miscompares++; $display("FAIL illegal_sticky cleared_cycles=%0d want=0", err_lost); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if (error !== 1'b0 || obs_vec !== exp_vec) begin
            miscompares++; $display("FAIL illegal_rst_clear err=%b got=%h want=%h", error, obs_vec, exp_vec);
        end
    endtask

    task automatic test_watchdog();
        int n = 0; int bad = 0;
        run = 1'b1; fetch_ack = 1'b0; stall = 1'b0;
        while (!fetch_req && n < 5) begin tick(); n++; end
`ifdef FETCH_WATCHDOG_EN
        n = 1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (obs_vec !== exp_vec) bad++;
            if (!fetch_req) break;
            n++;
        end
        vectors++;
        if (n !== WD_LIMIT) begin miscompares++; $display("FAIL wd_high_len got=%0d want=%0d", n, WD_LIMIT); end
        vectors++;
        if (fetch_req !== 1'b0 || error !== 1'b1) begin
            miscompares++; $display("FAIL wd_drop req=%b err=%b want 0/1", fetch_req, error);
        end
        tick();
        if (obs_vec !== exp_vec) bad++;
        vectors++;
        if (fetch_req !== 1'b1 || state !== 3'b001 || bad !== 0) begin
            miscompares++; $display("FAIL wd_reassert req=%b state=%b bad=%0d want 1/001/0", fetch_req, state, bad);
        end
`else
        for (int i = 0; i < 110; i++) begin
            tick();
            if (obs_vec !== exp_vec || fetch_req !== 1'b1) bad++;
        end
        vectors++;
        if (bad !== 0 || error !== 1'b0 || state !== 3'b001) begin
            miscompares++; $display("FAIL wd_absent_hold bad=%0d err=%b state=%b want 0/0/001", bad, error, state);
        end
`endif
        run = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_random();
        int bad = 0; int first_bad = -1;
        logic [VEC_W-1:0] bad_obs = '0, bad_exp = '0;
        for (int i = 0; i < 600; i++) begin
            rst         = ($urandom_range(0, 63) == 0);
            scan_enable = ($urandom_range(0, 15) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            run         = ($urandom_range(0, 3) != 0);
            fetch_ack   = ($urandom_range(0, 1) == 1);
            exec_cycles = CNT_W'($urandom_range(0, 6));
            tick();
            if (obs_vec !== exp_vec) begin
                if (first_bad < 0) begin first_bad = i; bad_obs = obs_vec; bad_exp = exp_vec; end
                bad++;
            end
        end
        rst = 1'b0; scan_enable = 1'b0; stall = 1'b0; run = 1'b0; fetch_ack = 1'b0;
        vectors++;
        if (bad !== 0) begin
            miscompares++;
            $display("FAIL random_model bad_cycles=%0d first=%0d got=%h want=%h", bad, first_bad, bad_obs, bad_exp);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_basic();
        test_exec_zero();
        test_stall();
        test_run_low();
        test_reset_mid();
        test_retire_wrap();
        test_illegal();
        test_watchdog();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
